column_pixel_responder: RTL and testbench

Per-column responder for the plotter's column-write handshake (col_select[k] / row_select / pixel_color / return_sig[k]). One instance per screen column: 64 instances, indexed k = 0..63. Each instance owns an M10K-backed store of ROWS 8-bit pixels. It accepts single-pixel writes from the plotting FSM, acknowledges each one, and serves a free-running VGA read port. It also supports a bulk clear sweep.

---
 rtl/column_pixel_responder.sv | 142 ++++++++++++++
 tb/tb_column_pixel_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/column_pixel_responder.sv
// Per-column pixel store: accepts single-pixel writes over a four-phase
// sel/ack handshake, runs a bulk clear sweep, and serves a VGA read port.
module column_pixel_responder #(
    parameter int          ROWS        = 480,
    parameter int          ADDR_W      = 9,
    parameter logic [7:0]  CLEAR_COLOR = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sel,
    input  logic [9:0]        row_select,
    input  logic [7:0]        pixel_color,
    output logic              ack,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [7:0]        vga_data,
    output logic [7:0]        oob_count
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        ACK,
        CLEAR
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] lat_row, lat_row_n;
    logic [ADDR_W-1:0] clr_addr, clr_addr_n;
    logic [7:0]        lat_color, lat_color_n;
    logic [7:0]        oob_n;
    logic              we, we_n;
    logic              ack_n, busy_n, done_n;
    logic              in_range;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem [0:ROWS-1];

    // Full 10-bit compare so rows >= 512 are never aliased into range
    assign in_range = {22'd0, row_select} < $unsigned(ROWS);

    always_comb begin
        state_n     = state;
        lat_row_n   = lat_row;
        lat_color_n = lat_color;
        clr_addr_n  = clr_addr;
        oob_n       = oob_count;
        we_n        = 1'b0;
        ack_n       = ack;
        busy_n      = clear_busy;
        done_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n    = CLEAR;
                    clr_addr_n = '0;
                    busy_n     = 1'b1;
                end else if (sel) begin
                    lat_row_n   = row_select[ADDR_W-1:0];
                    lat_color_n = pixel_color;
                    if (in_range) begin
                        we_n    = 1'b1;
                        state_n = WRITE;
                    end else begin
                        if (oob_count != 8'hFF)
                            oob_n = oob_count + 8'd1;
                        state_n = ACK;
                        ack_n   = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_n = ACK;
                ack_n   = 1'b1;
            end
            ACK: begin
                if (!sel) begin
                    state_n = IDLE;
                    ack_n   = 1'b0;
                end
            end
            CLEAR: begin
                clr_addr_n = clr_addr + 1'b1;
                if (clr_addr == ADDR_W'(ROWS - 1)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            lat_row    <= '0;
            lat_color  <= '0;
            clr_addr   <= '0;
            oob_count  <= '0;
            we         <= 1'b0;
            ack        <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_n;
            lat_row    <= lat_row_n;
            lat_color  <= lat_color_n;
            clr_addr   <= clr_addr_n;
            oob_count  <= oob_n;
            we         <= we_n;
            ack        <= ack_n;
            clear_busy <= busy_n;
            clear_done <= done_n;
        end
    end

    // Single write port shared by pixel writes and the clear sweep
    always_comb begin
        mem_we    = !reset &&
                    ((state == WRITE && we) || state == CLEAR);
        mem_addr  = (state == CLEAR) ? clr_addr : lat_row;
        mem_wdata = (state == CLEAR) ? CLEAR_COLOR : lat_color;
    end

    always_ff @(posedge clock) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset)
            vga_data <= '0;
        else
            vga_data <= mem[vga_addr];
    end

endmodule

// File: tb/tb_column_pixel_responder.sv
// Directed + randomized bench for column_pixel_responder against a
// row-array reference model of the pixel store and out-of-range counter.
module tb_column_pixel_responder;

    localparam int ROWS = 480;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sel = 1'b0;
    logic [9:0] row_select = '0;
    logic [7:0] pixel_color = '0;
    logic       ack;
    logic       clear_req = 1'b0;
    logic       clear_busy;
    logic       clear_done;
    logic [8:0] vga_addr = '0;
    logic [7:0] vga_data;
    logic [7:0] oob_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_mem [ROWS];
    bit         known [ROWS];
    int         oob_m = 0;

    column_pixel_responder dut (
        .clock(clock),
        .reset(reset),
        .sel(sel),
        .row_select(row_select),
        .pixel_color(pixel_color),
        .ack(ack),
        .clear_req(clear_req),
        .clear_busy(clear_busy),
        .clear_done(clear_done),
        .vga_addr(vga_addr),
        .vga_data(vga_data),
        .oob_count(oob_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input int addr);
        vga_addr = addr[8:0];
        tick();
        if (known[addr])
            chk($sformatf("read_row%0d", addr), {24'd0, vga_data},
                {24'd0, exp_mem[addr]});
    endtask

    task automatic wait_ack(input int limit);
        int n;
        n = 0;
        while (!ack && n < limit) begin
            tick();
            n++;
        end
        if (!ack)
            chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic model_write(input int row, input logic [7:0] c);
        if (row < ROWS) begin
            exp_mem[row] = c;
            known[row]   = 1'b1;
        end else if (oob_m < 255) begin
            oob_m++;
        end
    endtask

    task automatic do_req(input int row, input logic [7:0] c);
        sel         = 1'b1;
        row_select  = row[9:0];
        pixel_color = c;
        tick();
        wait_ack(10);
        sel = 1'b0;
        row_select  = 10'($urandom);
        pixel_color = 8'($urandom);
        tick();
        chk("ack_fall", {31'd0, ack}, 32'd0);
        model_write(row, c);
    endtask

    initial begin
        int r;
        int bcnt, dcnt, ack_busy;
        logic [7:0] c, c0;

        for (int i = 0; i < ROWS; i++) known[i] = 1'b0;

        // 1: reset state, then first write timing
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, clear_busy}, 32'd0);
        chk("rst_done", {31'd0, clear_done}, 32'd0);
        chk("rst_oob", {24'd0, oob_count}, 32'd0);
        chk("rst_vga", {24'd0, vga_data}, 32'd0);

        sel = 1'b1; row_select = 10'd5; pixel_color = 8'hFF;
        tick();
        chk("ack_n0", {31'd0, ack}, 32'd0);
        tick();
        tick();
        chk("ack_n2", {31'd0, ack}, 32'd1);
        sel = 1'b0;
        tick();
        chk("ack_drop", {31'd0, ack}, 32'd0);
        model_write(5, 8'hFF);
        read_chk(5);

        // 2: back-to-back at both row boundaries
        do_req(0, 8'h10);
        do_req(479, 8'h20);
        read_chk(0);
        read_chk(479);
        chk("oob_zero", {24'd0, oob_count}, 32'd0);

        // 3: out-of-range, then saturation
        do_req(480, 8'hAA);
        read_chk(479);
        chk("oob_one", {24'd0, oob_count}, 32'(oob_m));
        for (int i = 0; i < 300; i++)
            do_req(int'($urandom_range(1023, 480)), 8'($urandom));
        chk("oob_sat", {24'd0, oob_count}, 32'd255);
        chk("oob_model", {24'd0, oob_count}, 32'(oob_m));

        // randomized in-range traffic with readback
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(ROWS - 1, 0));
            do_req(r, 8'($urandom));
            read_chk(r);
        end

        // 4: clear sweep with a request arriving mid-sweep
        c = 8'($urandom) | 8'h01;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clr_busy_rise", {31'd0, clear_busy}, 32'd1);
        bcnt = 1; dcnt = 0; ack_busy = 0;
        for (int i = 0; i < 490; i++) begin
            if (i == 9) begin
                sel = 1'b1; row_select = 10'd7; pixel_color = c;
            end
            tick();
            if (clear_busy) bcnt++;
            if (clear_done) dcnt++;
            if (ack && clear_busy) ack_busy++;
        end
        chk("clr_busy_len", 32'(bcnt), 32'd480);
        chk("clr_done_cnt", 32'(dcnt), 32'd1);
        chk("clr_ack_busy", 32'(ack_busy), 32'd0);
        chk("clr_ack_after", {31'd0, ack}, 32'd1);
        sel = 1'b0;
        tick();
        chk("clr_ack_fall", {31'd0, ack}, 32'd0);
        for (int i = 0; i < ROWS; i++) begin
            exp_mem[i] = 8'h00;
            known[i]   = 1'b1;
        end
        exp_mem[7] = c;
        for (int i = 0; i < ROWS; i++) read_chk(i);

        // 5a: reset while in ACK
        r = int'($urandom_range(ROWS - 1, 0));
        c = 8'($urandom);
        sel = 1'b1; row_select = r[9:0]; pixel_color = c;
        tick();
        wait_ack(10);
        reset = 1'b1;
        tick();
        chk("rst_ack_ack", {31'd0, ack}, 32'd0);
        chk("rst_ack_busy", {31'd0, clear_busy}, 32'd0);
        reset = 1'b0;
        sel = 1'b0;
        oob_m = 0;
        model_write(r, c);
        read_chk(r);
        chk("rst_oob_clr", {24'd0, oob_count}, 32'd0);

        // 5b: reset mid-clear at clr_addr=200
        do_req(3, 8'h33);
        do_req(199, 8'h99);
        do_req(200, 8'h5A);
        do_req(350, 8'hC3);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        chk("mid_clr_busy", {31'd0, clear_busy}, 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", {31'd0, clear_busy}, 32'd0);
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        chk("mid_rst_done", {31'd0, clear_done}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 200; i++) exp_mem[i] = 8'h00;
        read_chk(3);
        read_chk(199);
        read_chk(200);
        read_chk(350);
        for (int i = 0; i < 8; i++)
            read_chk(int'($urandom_range(ROWS - 1, 0)));

        // 6: sel held 50 cycles with colour churning
        r = int'($urandom_range(ROWS - 1, 0));
        c0 = 8'($urandom);
        sel = 1'b1; row_select = r[9:0]; pixel_color = c0;
        tick();
        ack_busy = 0;
        for (int i = 0; i < 50; i++) begin
            pixel_color = 8'($urandom);
            row_select  = 10'($urandom);
            vga_addr    = r[8:0];
            tick();
            if (i >= 2 && !ack) ack_busy++;
        end
        chk("hold_ack_drops", 32'(ack_busy), 32'd0);
        chk("hold_vga", {24'd0, vga_data}, {24'd0, c0});
        sel = 1'b0;
        tick();
        chk("hold_ack_fall", {31'd0, ack}, 32'd0);
        model_write(r, c0);
        read_chk(r);
        chk("hold_oob", {24'd0, oob_count}, 32'(oob_m));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
